// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU fetch / load-store ports, the arbiter and the Memory.
// master = CPU + Memory side, slave = arbiter side.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ren;
    logic                  mem_wen;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_addr, mem_ren, mem_wen, mem_din
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_addr, mem_ren, mem_wen, mem_din
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch port and the load/store port:
// one access in flight, round-robin under contention, fixed MEM_LATENCY access cycles.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LATENCY);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    generate
        if (MEM_LATENCY < 1) begin : g_bad_latency
            $fatal(1, "mem_port_arbiter: MEM_LATENCY must be >= 1");
        end
    endgenerate

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

    state_t        state_q, state_d;
    owner_t        owner_q, last_owner_q;
    logic [CW-1:0] count_q;
    logic          we_q;
    logic          grant_fetch, grant_data;
    logic          ren, wen;
    logic          last_cycle;

    assign last_cycle = (state_q == BUSY) && (count_q == CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Grants are gated by reset so nothing is accepted while reset is held.
    always_comb begin
        state_d     = state_q;
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        ren         = 1'b0;
        wen         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!reset) begin
                    if (bus.if_req && bus.d_req) begin
                        if (last_owner_q == OWN_FETCH) grant_data  = 1'b1;
                        else                           grant_fetch = 1'b1;
                    end else begin
                        grant_fetch = bus.if_req;
                        grant_data  = bus.d_req;
                    end
                    if (grant_fetch || grant_data) state_d = BUSY;
                end
            end
            BUSY: begin
                ren = (owner_q == OWN_FETCH) || !we_q;
                wen = (owner_q == OWN_DATA) && we_q;
                if (count_q == CNT_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.if_gnt  = grant_fetch;
    assign bus.d_gnt   = grant_data;
    assign bus.mem_ren = ren;
    assign bus.mem_wen = wen;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q       <= '0;
            owner_q       <= OWN_FETCH;
            last_owner_q  <= OWN_FETCH;
            we_q          <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_din   <= '0;
            bus.if_rdata  <= '0;
            bus.d_rdata   <= '0;
            bus.if_rvalid <= 1'b0;
            bus.d_rvalid  <= 1'b0;
        end else begin
            bus.if_rvalid <= 1'b0;
            bus.d_rvalid  <= 1'b0;
            if (grant_fetch || grant_data) begin
                count_q      <= LAT_LOAD;
                owner_q      <= grant_data ? OWN_DATA : OWN_FETCH;
                last_owner_q <= grant_data ? OWN_DATA : OWN_FETCH;
                we_q         <= grant_data && bus.d_we;
                bus.mem_addr <= grant_data ? bus.d_addr : bus.if_addr;
                if (grant_data) bus.mem_din <= bus.d_wdata;
            end else if (state_q == BUSY) begin
                count_q <= count_q - CNT_LAST;
                if (last_cycle) begin
                    if (owner_q == OWN_FETCH) begin
                        bus.if_rdata  <= bus.mem_dout;
                        bus.if_rvalid <= 1'b1;
                    end else begin
                        if (!we_q) bus.d_rdata <= bus.mem_dout;
                        bus.d_rvalid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter against a cycle-numbered transaction model:
// each grant at cycle T owns the memory for T+1..T+LAT and completes at T+LAT+1.
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic clock = 1'b0;
    logic reset;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_LATENCY(LAT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_1F0E;
    endfunction

    // Memory stand-in: returns junk unless a read is being driven.
    assign bus.mem_dout = bus.mem_ren ? mem_word(bus.mem_addr) : 32'hBAD0_BAD0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
        end
    endtask

    // Transaction-level reference state
    bit          m_busy    = 1'b0;
    int          m_start   = 0;
    bit          m_owner_d = 1'b0;
    bit          m_we      = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    bit          m_last_d  = 1'b0;
    logic [AW-1:0] m_mem_addr = '0;
    logic [DW-1:0] m_mem_din  = '0;
    logic [DW-1:0] m_if_rdata = '0;
    logic [DW-1:0] m_d_rdata  = '0;
    bit          m_if_gnt  = 1'b0;
    bit          m_d_gnt   = 1'b0;

    task automatic run_cycle(input bit rst, input bit ifr, input logic [AW-1:0] ifa,
                             input bit dr, input bit dwe, input logic [AW-1:0] da,
                             input logic [DW-1:0] dwd);
        bit acc, ren_e, wen_e, ifv_e, dv_e, gi, gd;
        @(posedge clock);
        #1;
        reset       = rst;
        bus.if_req  = ifr;
        bus.if_addr = ifa;
        bus.d_req   = dr;
        bus.d_we    = dwe;
        bus.d_addr  = da;
        bus.d_wdata = dwd;
        @(negedge clock);

        acc   = m_busy && (cyc > m_start) && (cyc <= m_start + LAT);
        ren_e = acc && (!m_owner_d || !m_we);
        wen_e = acc && m_owner_d && m_we;
        ifv_e = 1'b0;
        dv_e  = 1'b0;
        if (m_busy && cyc == m_start + LAT + 1) begin
            m_busy = 1'b0;
            if (!m_owner_d) begin
                ifv_e      = 1'b1;
                m_if_rdata = mem_word(m_addr);
            end else begin
                dv_e = 1'b1;
                if (!m_we) m_d_rdata = mem_word(m_addr);
            end
        end
        gi = 1'b0;
        gd = 1'b0;
        if (!rst && !m_busy) begin
            if (ifr && dr) begin
                if (m_last_d) gi = 1'b1;
                else          gd = 1'b1;
            end else begin
                gi = ifr;
                gd = dr;
            end
        end

        check_eq("if_gnt",    64'(bus.if_gnt),    64'(gi));
        check_eq("d_gnt",     64'(bus.d_gnt),     64'(gd));
        check_eq("mem_ren",   64'(bus.mem_ren),   64'(ren_e));
        check_eq("mem_wen",   64'(bus.mem_wen),   64'(wen_e));
        check_eq("if_rvalid", 64'(bus.if_rvalid), 64'(ifv_e));
        check_eq("d_rvalid",  64'(bus.d_rvalid),  64'(dv_e));
        check_eq("if_rdata",  64'(bus.if_rdata),  64'(m_if_rdata));
        check_eq("d_rdata",   64'(bus.d_rdata),   64'(m_d_rdata));
        check_eq("mem_addr",  64'(bus.mem_addr),  64'(m_mem_addr));
        if (wen_e || rst) check_eq("mem_din", 64'(bus.mem_din), 64'(m_mem_din));

        if (rst) begin
            m_busy     = 1'b0;
            m_last_d   = 1'b0;
            m_mem_addr = '0;
            m_mem_din  = '0;
            m_if_rdata = '0;
            m_d_rdata  = '0;
        end else if (gi || gd) begin
            m_busy     = 1'b1;
            m_start    = cyc;
            m_owner_d  = gd;
            m_we       = gd && dwe;
            m_addr     = gd ? da : ifa;
            m_last_d   = gd;
            m_mem_addr = m_addr;
            if (gd) m_mem_din = dwd;
        end
        m_if_gnt = gi;
        m_d_gnt  = gd;
        cyc++;
    endtask

    bit            r_rst, r_ifr, r_dr, r_dwe;
    logic [AW-1:0] r_ifa, r_da;
    logic [DW-1:0] r_dwd;

    initial begin
        reset       = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = '0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        // Reset held two cycles with both requests pending
        repeat (2) run_cycle(1, 1, 32'h0, 1, 0, 32'h0, 32'h0);

        // Lone fetch
        run_cycle(0, 1, 32'h40, 0, 0, 32'h0, 32'h0);
        repeat (3) run_cycle(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);

        // Contention held: alternates data / fetch / data
        repeat (8) run_cycle(0, 1, 32'h80, 1, 0, 32'h200, 32'h0);
        repeat (4) run_cycle(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);

        // Store
        run_cycle(0, 0, 32'h0, 1, 1, 32'h100, 32'hDEAD_BEEF);
        repeat (3) run_cycle(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);

        // Load aborted by reset, then a fresh load completes
        run_cycle(0, 0, 32'h0, 1, 0, 32'h300, 32'h0);
        run_cycle(1, 0, 32'h0, 0, 0, 32'h0, 32'h0);
        repeat (2) run_cycle(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
        run_cycle(0, 0, 32'h0, 1, 0, 32'h304, 32'h0);
        repeat (4) run_cycle(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);

        // Random traffic; pending requests keep their payload until granted or withdrawn
        r_ifr = 0; r_dr = 0; r_dwe = 0; r_ifa = '0; r_da = '0; r_dwd = '0;
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 99) == 0);
            if (r_ifr && !m_if_gnt) begin
                if ($urandom_range(0, 15) == 0) r_ifr = 0;
            end else begin
                r_ifr = ($urandom_range(0, 2) != 0);
                r_ifa = $urandom & 32'hFFFF_FFFC;
            end
            if (r_dr && !m_d_gnt) begin
                if ($urandom_range(0, 15) == 0) r_dr = 0;
            end else begin
                r_dr  = ($urandom_range(0, 2) != 0);
                r_dwe = $urandom_range(0, 1) == 1;
                r_da  = $urandom & 32'hFFFF_FFFC;
                r_dwd = $urandom;
            end
            run_cycle(r_rst, r_ifr, r_ifa, r_dr, r_dwe, r_da, r_dwd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
